rc_failsafe: RTL and testbench

RC_FAILSAFE -- requirements
Module: rc_failsafe

---
 rtl/px4_rc_pkg.sv | 25 ++
 rtl/us_tick_gen.sv | 27 ++
 rtl/rc_failsafe.sv | 167 ++++++++++++++++
 tb/tb_rc_failsafe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/px4_rc_pkg.sv
// Shared definitions for the RC failsafe block: state codes, default channel
// limits and failsafe width, plus the channel range test.
package px4_rc_pkg;

  typedef enum logic [2:0] {
    NO_SIGNAL = 3'd0,
    ARMING    = 3'd1,
    LIVE      = 3'd2,
    HOLD      = 3'd3,
    FAILSAFE  = 3'd4
  } rc_state_t;

  localparam int FS_WIDTH_DEF = 1000;
  localparam int MIN_US_DEF   = 900;
  localparam int MAX_US_DEF   = 2100;
  localparam int WIDTH_W      = 16;
  localparam int TIMER_W      = 20;

  function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                     input logic [WIDTH_W-1:0] lo,
                                     input logic [WIDTH_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick: one-cycle pulse every CLK_PER_US clocks.
module us_tick_gen #(
  parameter int CLK_PER_US = 25
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_US - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/rc_failsafe.sv
// RC receiver failsafe: validates decoded frames, arms after consecutive good
// frames, holds then falls back to a fixed width when frames stop.
module rc_failsafe
  import px4_rc_pkg::*;
#(
  parameter int CLK_PER_US  = 25,
  parameter int MIN_US      = MIN_US_DEF,
  parameter int MAX_US      = MAX_US_DEF,
  parameter int HOLD_US     = 40000,
  parameter int FAILSAFE_US = 500000,
  parameter int ARM_FRAMES  = 3,
  parameter int FS_WIDTH    = FS_WIDTH_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        frame_stb_i,
  input  logic [15:0] ch1_i,
  input  logic [15:0] ch2_i,
  input  logic [15:0] ch3_i,
  input  logic [15:0] ch4_i,
  input  logic [15:0] host1_i,
  input  logic [15:0] host2_i,
  input  logic [15:0] host3_i,
  input  logic [15:0] host4_i,
  input  logic        host_sel_i,
  output logic [15:0] width1_o,
  output logic [15:0] width2_o,
  output logic [15:0] width3_o,
  output logic [15:0] width4_o,
  output logic [2:0]  state_o,
  output logic [7:0]  bad_cnt_o
);

  localparam logic [WIDTH_W-1:0] MIN_W  = WIDTH_W'(MIN_US);
  localparam logic [WIDTH_W-1:0] MAX_W  = WIDTH_W'(MAX_US);
  localparam logic [WIDTH_W-1:0] FS_W   = WIDTH_W'(FS_WIDTH);
  localparam logic [TIMER_W-1:0] HOLD_T = TIMER_W'(HOLD_US);
  localparam logic [TIMER_W-1:0] FS_T   = TIMER_W'(FAILSAFE_US);
  localparam logic [7:0]         ARM_N  = 8'(ARM_FRAMES);

  logic                          tick;
  logic [TIMER_W-1:0]            timer;
  logic [TIMER_W-1:0]            timer_inc;
  logic                          hold_hit;
  logic                          fs_hit;
  logic                          ch_ok;
  logic                          frame_good;
  logic                          frame_bad;
  logic                          load;
  rc_state_t                     state, state_nxt;
  rc_state_t                     entry_q, entry_nxt;
  logic [7:0]                    arm_cnt, arm_nxt;
  logic [7:0]                    bad_cnt;
  logic [3:0][WIDTH_W-1:0]       ch_in;
  logic [3:0][WIDTH_W-1:0]       host_in;
  logic [3:0][WIDTH_W-1:0]       held_q, held_nxt;
  logic [3:0][WIDTH_W-1:0]       width_q, out_nxt;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .tick_o   (tick)
  );

  assign ch_in   = {ch4_i, ch3_i, ch2_i, ch1_i};
  assign host_in = {host4_i, host3_i, host2_i, host1_i};

  // frame_stb_i is a one-cycle valid with no ready: the frame is always
  // consumed in the cycle it is strobed, so ch*_i only matter in that cycle.
  always_comb begin
    ch_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!in_window(ch_in[i], MIN_W, MAX_W)) ch_ok = 1'b0;
    end
  end

  assign frame_good = frame_stb_i && ch_ok;
  assign frame_bad  = frame_stb_i && !ch_ok;

  // Thresholds compare the post-tick value so a timeout lands on the same edge
  // the timer reaches it; a good frame on that edge still wins.
  assign timer_inc = (tick && (timer != '1)) ? timer + TIMER_W'(1) : timer;
  assign hold_hit  = (timer_inc >= HOLD_T);
  assign fs_hit    = (timer_inc >= FS_T);

  always_comb begin
    state_nxt = state;
    entry_nxt = entry_q;
    arm_nxt   = arm_cnt;
    load      = 1'b0;
    case (state)
      NO_SIGNAL, FAILSAFE: begin
        if (frame_good) begin
          entry_nxt = state;
          arm_nxt   = 8'd1;
          if (ARM_N <= 8'd1) begin
            state_nxt = LIVE;
            load      = 1'b1;
          end else begin
            state_nxt = ARMING;
          end
        end
      end
      ARMING: begin
        if (frame_good) begin
          arm_nxt = arm_cnt + 8'd1;
          if (arm_nxt >= ARM_N) begin
            state_nxt = LIVE;
            load      = 1'b1;
          end
        end else if (frame_bad) begin
          state_nxt = entry_q;
          arm_nxt   = 8'd0;
        end
      end
      LIVE: begin
        if (frame_good) load = 1'b1;
        else if (hold_hit) state_nxt = HOLD;
      end
      HOLD: begin
        if (frame_good) begin
          state_nxt = LIVE;
          load      = 1'b1;
        end else if (fs_hit) begin
          state_nxt = FAILSAFE;
        end
      end
      default: state_nxt = NO_SIGNAL;
    endcase
  end

  always_comb begin
    held_nxt = load ? ch_in : held_q;
    out_nxt  = {4{FS_W}};
    if ((state_nxt == LIVE) || (state_nxt == HOLD)) begin
      out_nxt = host_sel_i ? host_in : held_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= NO_SIGNAL;
      entry_q <= NO_SIGNAL;
      arm_cnt <= 8'd0;
      timer   <= '0;
      bad_cnt <= 8'd0;
      held_q  <= {4{FS_W}};
      width_q <= {4{FS_W}};
    end else begin
      state   <= state_nxt;
      entry_q <= entry_nxt;
      arm_cnt <= arm_nxt;
      timer   <= frame_good ? '0 : timer_inc;
      if (frame_bad && (bad_cnt != 8'hFF)) bad_cnt <= bad_cnt + 8'd1;
      held_q  <= held_nxt;
      width_q <= out_nxt;
    end
  end

  assign width1_o  = width_q[0];
  assign width2_o  = width_q[1];
  assign width3_o  = width_q[2];
  assign width4_o  = width_q[3];
  assign state_o   = state;
  assign bad_cnt_o = bad_cnt;

endmodule

// File: tb/tb_rc_failsafe.sv
// Directed bench for rc_failsafe with shortened timeouts so the full
// NO_SIGNAL -> LIVE -> HOLD -> FAILSAFE path fits in a short run.
module tb_rc_failsafe;

  localparam int CLK_PER_US  = 2;
  localparam int HOLD_US     = 400;
  localparam int FAILSAFE_US = 3000;
  localparam int HOLD_CYC    = CLK_PER_US * HOLD_US;
  localparam int FS_CYC      = CLK_PER_US * FAILSAFE_US;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [15:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
  logic [15:0] host1 = '0, host2 = '0, host3 = '0, host4 = '0;
  logic        host_sel = 1'b0;
  logic [15:0] w1, w2, w3, w4;
  logic [2:0]  st;
  logic [7:0]  bad_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rc_failsafe #(
    .CLK_PER_US  (CLK_PER_US),
    .HOLD_US     (HOLD_US),
    .FAILSAFE_US (FAILSAFE_US)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .frame_stb_i (stb),
    .ch1_i       (ch1),
    .ch2_i       (ch2),
    .ch3_i       (ch3),
    .ch4_i       (ch4),
    .host1_i     (host1),
    .host2_i     (host2),
    .host3_i     (host3),
    .host4_i     (host4),
    .host_sel_i  (host_sel),
    .width1_o    (w1),
    .width2_o    (w2),
    .width3_o    (w3),
    .width4_o    (w4),
    .state_o     (st),
    .bad_cnt_o   (bad_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_widths(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_w1"}, 32'(w1), 32'(a));
    check({tag, "_w2"}, 32'(w2), 32'(b));
    check({tag, "_w3"}, 32'(w3), 32'(c));
    check({tag, "_w4"}, 32'(w4), 32'(d));
  endtask

  // Strobe one frame; returns on the falling edge right after it was sampled.
  task automatic send_frame(input int a, input int b, input int c, input int d);
    @(negedge clk);
    ch1 = 16'(a); ch2 = 16'(b); ch3 = 16'(c); ch4 = 16'(d);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while ((st !== s) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int m;
    int found;

    // Reset values
    idle(3);
    check("rst_state", 32'(st), 0);
    check("rst_bad_cnt", 32'(bad_cnt), 0);
    check_widths("rst", 1000, 1000, 1000, 1000);
    @(negedge clk);
    rst = 1'b0;

    // Arming: three good frames 100 us apart
    send_frame(1500, 1500, 1500, 1500);
    check("arm1_state", 32'(st), 1);
    check("arm1_w1", 32'(w1), 1000);
    idle(198);
    send_frame(1500, 1500, 1500, 1500);
    check("arm2_state", 32'(st), 1);
    idle(198);
    send_frame(1500, 1500, 1500, 1500);
    check("arm3_state", 32'(st), 2);
    check_widths("arm3", 1500, 1500, 1500, 1500);

    // Inclusive range limits are good
    send_frame(900, 2100, 1200, 1800);
    check("edge_state", 32'(st), 2);
    check_widths("edge", 900, 2100, 1200, 1800);

    // Bad frames are ignored for widths and counted
    send_frame(1500, 1500, 2500, 1500);
    check("bad1_cnt", 32'(bad_cnt), 1);
    check_widths("bad1", 900, 2100, 1200, 1800);
    send_frame(899, 1500, 1500, 1500);
    check("bad2_cnt", 32'(bad_cnt), 2);
    send_frame(1500, 1500, 1500, 2101);
    check("bad3_cnt", 32'(bad_cnt), 3);
    for (int i = 0; i < 297; i++) begin
      send_frame(1500, (i % 2 == 0) ? 0 : 65535, 1500, 1500);
    end
    check("bad_sat_cnt", 32'(bad_cnt), 255);
    check("bad_sat_state", 32'(st), 2);
    check_widths("bad_sat", 900, 2100, 1200, 1800);

    // Host override in LIVE, then timeout to HOLD and FAILSAFE
    send_frame(1300, 1400, 1600, 1700);
    @(negedge clk);
    host_sel = 1'b1; host1 = 16'd1800; host2 = 16'd1900; host3 = 16'd1200; host4 = 16'd1250;
    @(negedge clk);
    check("host_live_w1", 32'(w1), 1800);
    check("host_live_w2", 32'(w2), 1900);
    host_sel = 1'b0;
    @(negedge clk);
    check("host_off_w1", 32'(w1), 1300);
    wait_state(3'd3, 2000, n);
    check("hold_state", 32'(st), 3);
    check("hold_time", 32'((3 + n >= HOLD_CYC - 2) && (3 + n <= HOLD_CYC + 2)), 1);
    check_widths("hold", 1300, 1400, 1600, 1700);
    host_sel = 1'b1;
    @(negedge clk);
    check("host_hold_w1", 32'(w1), 1800);
    wait_state(3'd4, FS_CYC, m);
    check("fs_state", 32'(st), 4);
    check("fs_time", 32'((4 + n + m >= FS_CYC - 2) && (4 + n + m <= FS_CYC + 2)), 1);
    check_widths("fs", 1000, 1000, 1000, 1000);
    host_sel = 1'b0;

    // From FAILSAFE: bad frame while arming returns to FAILSAFE
    send_frame(1500, 1500, 1500, 1500);
    check("fsarm_state", 32'(st), 1);
    check("fsarm_w1", 32'(w1), 1000);
    send_frame(1500, 1500, 1500, 600);
    check("fsarm_abort_state", 32'(st), 4);
    send_frame(1500, 1500, 1500, 1500);
    check("rearm1_state", 32'(st), 1);
    send_frame(1500, 1500, 1500, 1500);
    check("rearm2_state", 32'(st), 1);
    send_frame(1500, 1500, 1500, 1500);
    check("rearm3_state", 32'(st), 2);
    check_widths("rearm3", 1500, 1500, 1500, 1500);

    // Good frame in the same tick the timer reaches HOLD_US
    found = 0;
    for (int i = 0; i < HOLD_CYC + 20; i++) begin
      @(negedge clk);
      if ((dut.timer == 20'(HOLD_US - 1)) && dut.tick) begin
        found = 1;
        break;
      end
    end
    check("tie_sync", 32'(found), 1);
    ch1 = 16'd1600; ch2 = 16'd1600; ch3 = 16'd1600; ch4 = 16'd1600;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("tie_state", 32'(st), 2);
    check("tie_timer", 32'(dut.timer), 0);
    check("tie_w1", 32'(w1), 1600);

    // Reset mid-operation, with a good frame strobed alongside it
    @(negedge clk);
    rst = 1'b1;
    ch1 = 16'd1700; ch2 = 16'd1700; ch3 = 16'd1700; ch4 = 16'd1700;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check("midrst_state", 32'(st), 0);
    check("midrst_bad_cnt", 32'(bad_cnt), 0);
    check_widths("midrst", 1000, 1000, 1000, 1000);
    rst = 1'b0;
    idle(2);
    check("postrst_state", 32'(st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
